// File: rtl/mp64_div_pkg.sv
// Shared types and constants for the mp64 iterative divider.
package mp64_div_pkg;

  localparam int unsigned DIV_STEPS = 64;
  localparam int unsigned CNT_W     = $clog2(DIV_STEPS);

  localparam logic [63:0] SIGNED_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } div_state_t;

  // Two's-complement negate when en is set, pass through otherwise.
  function automatic logic [63:0] neg_if(input logic en, input logic [63:0] v);
    return en ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mp64_div_step.sv
// One radix-2 restoring division iteration (purely combinational).
module mp64_div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // rem < dvs on entry, so the 65-bit trial never overflows and its MSB is the sign.
  always_comb begin
    trial   = {rem, dvd_msb} - {1'b0, dvs};
    q_bit   = ~trial[WIDTH];
    rem_nxt = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd_msb};
  end

endmodule

// File: rtl/mp64_div.sv
// Iterative 64-bit signed/unsigned divider with start/done/busy handshake.
module mp64_div
  import mp64_div_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             done,
  output logic             busy
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             special_q, special_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  assign abs_a = neg_if(is_signed & a[WIDTH-1], a);
  assign abs_b = neg_if(is_signed & b[WIDTH-1], b);

  mp64_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (rem_q),
    .dvd_msb(dvd_q[WIDTH-1]),
    .dvs    (dvs_q),
    .rem_nxt(step_rem),
    .q_bit  (step_q_bit)
  );

  // Next-state and datapath decode for the IDLE/RUN/FIX/DONE sequence.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rem_d         = rem_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    special_d     = special_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          q_neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg_d   = is_signed & a[WIDTH-1];
          special_d = 1'b0;
          dbz_d     = 1'b0;
          rem_d     = '0;
          dvd_d     = abs_a;
          dvs_d     = abs_b;
          count_d   = CNT_W'(DIV_STEPS - 1);
          state_d   = StRun;
          if (b == '0) begin
            special_d = 1'b1;
            dbz_d     = 1'b1;
            dvd_d     = '1;
            rem_d     = a;
            state_d   = StFix;
          end else if (is_signed && (a == SIGNED_MIN) && (b == '1)) begin
            // Overflow case: the true quotient is not representable, wrap to MIN.
            special_d = 1'b1;
            dvd_d     = SIGNED_MIN;
            rem_d     = '0;
            state_d   = StFix;
          end
        end
      end
      StRun: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q_bit};
        if (count_q == '0) begin
          state_d = StFix;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StFix: begin
        quotient_d    = special_q ? dvd_q : neg_if(q_neg_q, dvd_q);
        remainder_d   = special_q ? rem_q : neg_if(r_neg_q, rem_q);
        div_by_zero_d = dbz_q;
        done_d        = 1'b1;
        state_d       = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      count_q       <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      special_q     <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rem_q         <= rem_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      special_q     <= special_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign done        = done_q;
  assign busy        = ~rst & (start | (state_q != StIdle));

endmodule

// File: tb/tb_mp64_div.sv
// Directed-vector bench for mp64_div.
module tb_mp64_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;
  logic        done;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  mp64_div #(
    .WIDTH(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .a          (a),
    .b          (b),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive start for one cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input logic sig, input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sig;
    a         = av;
    b         = bv;
    #1;
    check("busy_c0", 64'(busy), 64'd1);
    @(negedge clk);
    start     = 1'b0;
    is_signed = ~sig;
    a         = 64'hDEAD_BEEF_0BAD_F00D;
    b         = 64'h1234_5678_9ABC_DEF0;
  endtask

  // Wait for done starting at cycle 'from'; lat is the cycle done was seen, -1 on timeout.
  task automatic wait_done(input int from, output int lat);
    lat = -1;
    for (int c = from; c <= from + 120; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic sig, input logic [63:0] av,
                        input logic [63:0] bv, input int exp_lat, input logic [63:0] eq,
                        input logic [63:0] er, input logic edz);
    int lat;
    issue(sig, av, bv);
    wait_done(1, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_q_held"}, quotient, eq);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    start     = 1'b1;
    is_signed = 1'b0;
    a         = 64'd0;
    b         = 64'd0;
    repeat (2) @(negedge clk);
    check("rst_busy_forced", 64'(busy), 64'd0);
    check("rst_q", quotient, 64'd0);
    check("rst_r", remainder, 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    run_op("u100_7", 1'b0, 64'd100, 64'd7, 66, 64'd14, 64'd2, 1'b0);
    run_op("s-7_2", 1'b1, -64'sd7, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFD,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("s7_-2", 1'b1, 64'd7, -64'sd2, 66, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0);
    run_op("s-100_-7", 1'b1, -64'sd100, -64'sd7, 66, 64'd14,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("u-7_2", 1'b0, -64'sd7, 64'd2, 66, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 1'b0);
    run_op("u5_0", 1'b0, 64'd5, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1);
    run_op("smin_-1", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2,
           64'h8000_0000_0000_0000, 64'd0, 1'b0);
    run_op("umin_-1", 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 66,
           64'd0, 64'h8000_0000_0000_0000, 1'b0);

    // Second start during RUN must be ignored.
    issue(1'b0, 64'd1000, 64'd10);
    repeat (9) @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b1;
    a         = 64'd77;
    b         = 64'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, lat);
    check("ign_lat", 64'(lat), 64'd66);
    check("ign_q", quotient, 64'd100);
    check("ign_r", remainder, 64'd0);
    @(negedge clk);
    check("ign_one_pulse", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("ign_no_queue", 64'(busy), 64'd0);

    run_op("u_ones_1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);

    // Reset in cycle 30 aborts; restart right after must finish at +66.
    issue(1'b0, 64'd100, 64'd7);
    repeat (29) @(negedge clk);
    check("mid_q_held", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b1;
    is_signed = 1'b0;
    a         = 64'd1000;
    b         = 64'd7;
    #1;
    check("abort_q", quotient, 64'd0);
    check("abort_r", remainder, 64'd0);
    check("abort_dbz", 64'(div_by_zero), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    a     = 64'd0;
    b     = 64'd0;
    wait_done(1, lat);
    check("restart_lat", 64'(lat), 64'd66);
    check("restart_q", quotient, 64'd142);
    check("restart_r", remainder, 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mp64_div.md
# mp64_div

Iterative 64-bit integer divider, the inverse counterpart of the `mp64_mul` multiplier. It shares that block's start/done/busy handshake so the execute stage can drive both from the same issue logic. It sits beside `mp64_mul` in the ALU long-op path and serves DIV/MOD/UDIV/UMOD. Implementation is radix-2 restoring: one quotient bit per cycle, with sign fix-up and special cases handled in dedicated states.

## Interface
Parameters:
- `WIDTH`, default 64: operand width. Only 64 is supported; the parameter exists for bench scaling.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `is_signed`  in  1  1 selects two's-complement operands; 0 selects unsigned. Sampled with `start`.
- `a`  in  WIDTH  dividend, sampled with `start`.
- `b`  in  WIDTH  divisor, sampled with `start`.
- `quotient`  out  WIDTH  result quotient. Held until the next accepted start.
- `remainder`  out  WIDTH  result remainder. Held until the next accepted start.
- `div_by_zero`  out  1  flag for the last completed operation (`b == 0`). Held like the results.
- `done`  out  1  one-cycle pulse; results valid in that cycle.
- `busy`  out  1  `start | (state != IDLE)`. Forced to 0 while `rst` is high.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE with `start = 1`: latch `is_signed` and the operand magnitudes (negate negatives when signed); record the result signs.
  - Quotient sign: `a[63] ^ b[63]`.
  - Remainder sign: `a[63]`.
  - Next state is RUN with `count = 63`, unless a special case applies.
- Special cases, decided in IDLE, go straight to FIX:
  - `b == 0`: quotient = all ones, remainder = `a`, `div_by_zero = 1`. Applies in both signed and unsigned mode.
  - Signed `a = 0x8000_0000_0000_0000`, `b = 0xFFFF_FFFF_FFFF_FFFF`: quotient = `0x8000_0000_0000_0000`, remainder = 0.
- RUN, each cycle:
  - Form the 65-bit trial `{rem[63:0], dvd[63]} - {1'b0, dvs}`.
  - If non-negative: take the trial as the new remainder and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Shift the dividend left by one.
  - At `count == 0`, go to FIX; otherwise decrement `count`.
- FIX: apply the recorded signs by two's-complement negation (skipped for special cases). Register `quotient`, `remainder` and `div_by_zero`. Go to DONE.
- DONE: `done = 1` for exactly this cycle, then IDLE.
- Semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - `a == q*b + r` holds for all non-zero `b`.
- `start` in RUN, FIX or DONE is ignored: no queuing, no corruption of the in-flight operation. Masters must check `busy`.
- `a`, `b` and `is_signed` may change freely after the start cycle.
- Reset mid-operation aborts immediately:
  - State returns to IDLE.
  - `quotient`, `remainder` and `div_by_zero` clear to 0.
  - No `done` pulse is issued for the aborted operation.

## Timing
- Reset values: `quotient = 0`, `remainder = 0`, `div_by_zero = 0`, `done = 0`, `busy = 0`, state IDLE.
- With `start` high in cycle 0, the normal path is:
  - RUN in cycles 1–64.
  - FIX in cycle 65.
  - `done` high in cycle 66.
  - Next start accepted in cycle 67.
- Special-case path: FIX in cycle 1, `done` high in cycle 2, next start accepted in cycle 3.
- `busy` is high from cycle 0 through the `done` cycle inclusive.
- Outputs change only on the FIX→DONE edge and are stable while `done` is high.

## Structure
- Shared package `mp64_div_pkg`:
  - `div_state_t` enum (IDLE/RUN/FIX/DONE).
  - `DIV_STEPS = 64`.
  - `SIGNED_MIN` constant.
- Sub-module `mp64_div_step`: combinational single restoring iteration. Inputs are `rem`, `dvd_msb` and `dvs`; outputs are the new remainder and the quotient bit. It is instantiated once; a future radix-4 variant instantiates it twice.
- The top level owns the FSM, counter, sign handling and output registers.

## Test plan
- Unsigned 100 / 7: start in cycle 0 → `done` in cycle 66, q = 14, r = 2, `div_by_zero = 0`.
- Signed −7 / 2: q = `0xFFFF_FFFF_FFFF_FFFD` (−3), r = `0xFFFF_FFFF_FFFF_FFFF` (−1).
- Unsigned 5 / 0: `done` in cycle 2, q = `0xFFFF_FFFF_FFFF_FFFF`, r = 5, `div_by_zero = 1`.
- Signed `0x8000_0000_0000_0000` / −1: `done` in cycle 2, q = `0x8000_0000_0000_0000`, r = 0.
- Second start during RUN with different operands, followed by unsigned `0xFFFF_FFFF_FFFF_FFFF` / 1:
  - The second start is ignored: the first result completes unchanged, with exactly one `done` pulse.
  - The / 1 case gives q = all ones, r = 0.
- Reset during cycle 30 of an operation:
  - No `done` pulse; outputs read 0.
  - A new start in the cycle after reset deasserts completes normally at +66.
